// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: header field widths, arbiter FSM states,
// header record and a small modular-index helper for round-robin search.
package eth_pkg;

    localparam int MAC_W   = 48;
    localparam int ETYPE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
    } tx_state_e;

    typedef struct packed {
        logic [MAC_W-1:0]   dest_mac;
        logic [MAC_W-1:0]   src_mac;
        logic [ETYPE_W-1:0] eth_type;
    } eth_hdr_t;

    // (base + off) mod n for base < n and off <= n, without a divider
    function automatic int rr_wrap(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Header handshake bundle and AXI-Stream bundle used by the TX arbiter.

interface ETH_HEADER_IF;
    logic                        valid;
    logic                        ready;
    logic [eth_pkg::MAC_W-1:0]   dest_mac;
    logic [eth_pkg::MAC_W-1:0]   src_mac;
    logic [eth_pkg::ETYPE_W-1:0] eth_type;

    modport Master (output valid, dest_mac, src_mac, eth_type, input ready);
    modport Slave  (input valid, dest_mac, src_mac, eth_type, output ready);
endinterface

interface AXIS_IF #(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int ID_WIDTH    = 0,
    parameter int DEST_WIDTH  = 0,
    parameter int USER_WIDTH  = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport Master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport Slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter
    import eth_pkg::*;
#(
    parameter int N_PORTS = 2
) (
    input  logic [N_PORTS-1:0]         req,
    input  logic [$clog2(N_PORTS)-1:0] last_grant,
    output logic [$clog2(N_PORTS)-1:0] grant,
    output logic                       grant_valid
);

    localparam int IW = $clog2(N_PORTS);

    // Walk from lowest to highest priority so the nearest requester wins last
    always_comb begin
        grant       = '0;
        grant_valid = |req;
        for (int i = N_PORTS; i >= 1; i--) begin
            if (req[rr_wrap(int'(last_grant), i, N_PORTS)])
                grant = IW'(rr_wrap(int'(last_grant), i, N_PORTS));
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter granting one header+payload source at a time onto a
// shared TX framer. Header is registered; payload is a combinational mux.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int N_PORTS     = 2,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8)
) (
    input  logic                       clk,
    input  logic                       reset,
    ETH_HEADER_IF.Slave                hdr_in_if [N_PORTS],
    AXIS_IF.Slave                      payload_in_if [N_PORTS],
    ETH_HEADER_IF.Master               hdr_out_if,
    AXIS_IF.Master                     payload_out_if,
    output logic [$clog2(N_PORTS)-1:0] grant_idx,
    output logic                       busy
);

    localparam int IW     = $clog2(N_PORTS);
    localparam int KEEP_W = (DATA_WIDTH + 7) / 8;

    tx_state_e                            state;
    eth_hdr_t                             hdr_q;
    logic                                 hdr_valid_q;
    logic [IW-1:0]                        last_grant;
    logic [IW-1:0]                        rr_grant;
    logic                                 rr_valid;
    logic [N_PORTS-1:0]                   hdr_req;
    eth_hdr_t [N_PORTS-1:0]               hdr_vec;
    logic [N_PORTS-1:0][DATA_WIDTH-1:0]   pl_data;
    logic [N_PORTS-1:0][KEEP_W-1:0]       pl_keep;
    logic [N_PORTS-1:0]                   pl_valid;
    logic [N_PORTS-1:0]                   pl_last;
    logic [N_PORTS-1:0]                   pl_user;

    initial begin
        assert (N_PORTS >= 2 && N_PORTS <= 8);
        assert ($bits(payload_out_if.tdata) == DATA_WIDTH);
        assert (payload_out_if.ID_WIDTH == 0 && payload_out_if.DEST_WIDTH == 0);
        assert (payload_out_if.USER_WIDTH == 1);
        assert (payload_out_if.KEEP_ENABLE == KEEP_ENABLE);
    end

    // Flatten the interface arrays so the granted port can be picked by index;
    // readys are held low while reset is asserted so no handshake is lost.
    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        initial begin
            assert ($bits(payload_in_if[g].tdata) == DATA_WIDTH);
            assert (payload_in_if[g].ID_WIDTH == 0 && payload_in_if[g].DEST_WIDTH == 0);
            assert (payload_in_if[g].USER_WIDTH == 1);
            assert (payload_in_if[g].KEEP_ENABLE == KEEP_ENABLE);
        end

        assign hdr_req[g]  = hdr_in_if[g].valid;
        assign hdr_vec[g]  = {hdr_in_if[g].dest_mac, hdr_in_if[g].src_mac, hdr_in_if[g].eth_type};
        assign pl_data[g]  = payload_in_if[g].tdata;
        assign pl_keep[g]  = KEEP_ENABLE ? payload_in_if[g].tkeep : '1;
        assign pl_valid[g] = payload_in_if[g].tvalid;
        assign pl_last[g]  = payload_in_if[g].tlast;
        assign pl_user[g]  = payload_in_if[g].tuser[0];

        assign hdr_in_if[g].ready = reset && (state == IDLE) && rr_valid
                                    && (rr_grant == IW'(g));
        assign payload_in_if[g].tready = reset && (state == PAYLOAD)
                                         && (grant_idx == IW'(g)) && payload_out_if.tready;
    end

    rr_arbiter #(.N_PORTS(N_PORTS)) u_rr (
        .req         (hdr_req),
        .last_grant  (last_grant),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    // Frame sequencer: accept header, present it, then pass payload to tlast
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= IW'(N_PORTS - 1);
            hdr_valid_q <= 1'b0;
            hdr_q       <= '0;
            grant_idx   <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_valid) begin
                        grant_idx   <= rr_grant;
                        hdr_q       <= hdr_vec[rr_grant];
                        hdr_valid_q <= 1'b1;
                        busy        <= 1'b1;
                        state       <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_out_if.ready) begin
                        hdr_valid_q <= 1'b0;
                        state       <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (pl_valid[grant_idx] && payload_out_if.tready && pl_last[grant_idx]) begin
                        last_grant <= grant_idx;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hdr_out_if.valid    = hdr_valid_q;
    assign hdr_out_if.dest_mac = hdr_q.dest_mac;
    assign hdr_out_if.src_mac  = hdr_q.src_mac;
    assign hdr_out_if.eth_type = hdr_q.eth_type;

    assign payload_out_if.tdata  = pl_data[grant_idx];
    assign payload_out_if.tkeep  = pl_keep[grant_idx];
    assign payload_out_if.tlast  = pl_last[grant_idx];
    assign payload_out_if.tuser  = pl_user[grant_idx];
    assign payload_out_if.tvalid = reset && (state == PAYLOAD) && pl_valid[grant_idx];

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, meaning the number of requesting header+payload sources (legal range 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the payload tdata width in bits.
REQ-003 SHALL have parameter KEEP_ENABLE, default (DATA_WIDTH > 8), meaning tkeep is carried on all payload ports.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port hdr_in_if[N_PORTS], ETH_HEADER_IF.Slave: per-requester header (valid, ready, dest_mac, src_mac, eth_type).
REQ-007 SHALL have port payload_in_if[N_PORTS], AXIS_IF.Slave: per-requester payload stream (tuser width 1, no tid/tdest).
REQ-008 SHALL have port hdr_out_if, ETH_HEADER_IF.Master: header toward the shared TX framer.
REQ-009 SHALL have port payload_out_if, AXIS_IF.Master: payload toward the shared TX framer.
REQ-010 SHALL have port grant_idx, output, $clog2(N_PORTS) bits: index of the current owner, valid while busy.
REQ-011 SHALL have port busy, output, 1 bit: high from header acceptance until the owner's tlast handshake completes.

Function
REQ-012 SHALL implement FSM states IDLE, HDR, PAYLOAD.
REQ-013 In IDLE, when any hdr_in_if[i].valid is high, SHALL select one requester by round-robin, assert only that hdr_in_if[i].ready for exactly one cycle, capture its header into an output register, and move to HDR.
REQ-014 Round-robin: search SHALL start at (last_grant + 1) mod N_PORTS and wrap around; after reset last_grant = N_PORTS-1, so port 0 has priority.
REQ-015 In HDR, hdr_out_if.valid SHALL be high with the registered fields held stable until hdr_out_if.ready; on that handshake, move to PAYLOAD.
REQ-016 Header latency: hdr_out_if.valid SHALL rise exactly 1 cycle after the input header handshake.
REQ-017 In PAYLOAD, payload_out_if tdata/tkeep/tvalid/tlast/tuser SHALL combinationally follow payload_in_if[grant_idx], and payload_in_if[grant_idx].tready SHALL equal payload_out_if.tready.
REQ-018 On a payload beat with tvalid, tready and tlast all high, SHALL update last_grant to grant_idx and return to IDLE in the next cycle.
REQ-019 Outside PAYLOAD, payload_out_if.tvalid SHALL be 0; every non-granted payload_in_if tready and hdr_in_if ready SHALL always be 0.
REQ-020 Simultaneous requests SHALL be resolved by REQ-014 only; a requester raising valid during HDR or PAYLOAD SHALL wait, and no header is dropped.
REQ-021 A requester dropping hdr valid before being granted SHALL simply not be considered; no error SHALL be flagged.
REQ-022 Minimum gap between frames SHALL be one IDLE cycle (arbitration cycle).
REQ-023 A single-beat payload (tlast on the first beat) SHALL be handled identically to longer payloads.

Reset
REQ-024 With reset low at a clk edge: state = IDLE, last_grant = N_PORTS-1, hdr_out_if.valid = 0, header register = 0, grant_idx = 0, busy = 0, all input readys = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no further output beats; the remaining source beats are the requester's responsibility.

Structure
REQ-026 The FSM state enum and the MAC/ethertype width constants (48, 16) SHALL live in the shared eth_pkg package.
REQ-027 Round-robin selection SHALL be a separate sub-module rr_arbiter (request vector, last_grant in; grant index and grant_valid out; purely combinational).
REQ-028 Interface parameter checks (tdata width, TID/TDEST width 0, TUSER width 1, KEEP_ENABLE match) SHALL be initial assertions.

Verification
REQ-029 Single requester: port 1 sends dest 0xFFFFFFFFFFFF, type 0x0806, 4-beat payload -> header out 1 cycle later, 4 identical beats, grant_idx = 1, busy falls after the tlast beat.
REQ-030 Simultaneous: ports 0 and 1 valid in the same cycle after reset -> port 0 is served first, then port 1; frames are not interleaved.
REQ-031 Fairness: all 4 ports (N_PORTS = 4) continuously requesting for 8 frames -> grant order 0,1,2,3,0,1,2,3.
REQ-032 Backpressure: hdr_out_if.ready held low for 5 cycles, then payload tready toggling 1/0 -> header fields stable, no beat lost or duplicated, bytes match the source.
REQ-033 Reset mid-PAYLOAD after 2 of 6 beats -> next cycle tvalid = 0, busy = 0, and the next request goes to port 0.
REQ-034 Single-beat payload from port 2 (tlast on beat 1) -> one output beat, return to IDLE, next grant search starts at port 3.
